// File: rtl/ugemm_rate_pkg.sv
// Shared types and helpers for the rate-coded unary multiplier.
package ugemm_rate_pkg;

    typedef enum logic [1:0] {
        UMUL_IDLE = 2'd0,
        UMUL_RUN  = 2'd1,
        UMUL_DONE = 2'd2
    } umul_state_t;

    localparam int unsigned BITREV_MAX_W = 32;

    // Mirror the low w bits of v; bits at and above w come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] v,
        input int unsigned             w
    );
        logic [BITREV_MAX_W-1:0] r;
        logic [4:0]              idx;
        r   = {BITREV_MAX_W{1'b0}};
        idx = 5'd0;
        for (int i = 0; i < int'(BITREV_MAX_W); i++) begin
            if (i < int'(w)) begin
                idx  = 5'(int'(w) - 1 - i);
                r[i] = v[idx];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/umul_rate_rng_bitrev.sv
// Enable-gated up counter with synchronous clear; publishes its bit-reversed low bits as the RNG value.
module rng_bitrev
    import ugemm_rate_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [DATA_WIDTH:0]   cnt,
    output logic [DATA_WIDTH-1:0] rev
);

    logic [DATA_WIDTH:0] cnt_r;

    // Counter state: clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {(DATA_WIDTH+1){1'b0}};
        end else if (clr) begin
            cnt_r <= {(DATA_WIDTH+1){1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + {{DATA_WIDTH{1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Bit-reversed view spreads consecutive counts across the whole range.
    always_comb begin
        cnt = cnt_r;
        rev = DATA_WIDTH'(bitrev(BITREV_MAX_W'(cnt_r[DATA_WIDTH-1:0]), DATA_WIDTH));
    end

endmodule

// File: rtl/umul_rate.sv
// Rate-coded unary multiplier: emits ~ifm*wght/2^DATA_WIDTH ones per MAC window, then pulses mac_done.
// Optional UMUL_EARLY_TERM_EN adds a cyc_len input that shortens the window (0 selects the full length).
module umul_rate
    import ugemm_rate_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] ifm,
    input  logic [DATA_WIDTH-1:0] wght,
`ifdef UMUL_EARLY_TERM_EN
    input  logic [DATA_WIDTH-1:0] cyc_len,
`endif
    output logic                  busy,
    output logic                  prod_bit,
    output logic                  mac_done
);

    localparam logic [DATA_WIDTH:0] FULL_LEN = {1'b1, {DATA_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH:0] ONE_CNT  = {{DATA_WIDTH{1'b0}}, 1'b1};

    umul_state_t           state_r;
    umul_state_t           state_s;
    logic [DATA_WIDTH-1:0] ifm_r;
    logic [DATA_WIDTH-1:0] wght_r;
    logic [DATA_WIDTH:0]   cnt_i_s;
    logic [DATA_WIDTH:0]   cnt_w_unused_s;
    logic [DATA_WIDTH-1:0] rev_i_s;
    logic [DATA_WIDTH-1:0] rev_w_s;
    logic [DATA_WIDTH:0]   len_s;
    logic                  run_s;
    logic                  can_load_s;
    logic                  load_s;
    logic                  step_s;
    logic                  last_s;
    logic                  ifm_bit_s;
    logic                  wght_bit_s;
    logic                  cnt_clr_s;
    logic                  inc_w_s;

    // Control decode; clr suppresses loads and steps so it alone decides the next edge.
    always_comb begin
        run_s      = (state_r == UMUL_RUN);
        can_load_s = (state_r == UMUL_IDLE) || (state_r == UMUL_DONE);
        load_s     = en & ~clr & start & can_load_s;
        step_s     = en & ~clr & run_s;
        ifm_bit_s  = (ifm_r > rev_i_s);
        wght_bit_s = (wght_r > rev_w_s);
        cnt_clr_s  = clr | load_s;
        inc_w_s    = step_s & ifm_bit_s;
        last_s     = (cnt_i_s == (len_s - ONE_CNT));
    end

`ifdef UMUL_EARLY_TERM_EN
    logic [DATA_WIDTH-1:0] cyc_len_r;

    // Window length is captured with the operands so it cannot change mid-window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_len_r <= {DATA_WIDTH{1'b0}};
        end else if (load_s) begin
            cyc_len_r <= cyc_len;
        end else begin
            cyc_len_r <= cyc_len_r;
        end
    end

    // A zero length means a full 2^DATA_WIDTH window.
    always_comb begin
        if (cyc_len_r == {DATA_WIDTH{1'b0}}) begin
            len_s = FULL_LEN;
        end else begin
            len_s = {1'b0, cyc_len_r};
        end
    end
`else
    // Without early termination every window runs the full length.
    always_comb begin
        len_s = FULL_LEN;
    end
`endif

    // Operand registers, loaded only when a window is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_r  <= {DATA_WIDTH{1'b0}};
            wght_r <= {DATA_WIDTH{1'b0}};
        end else if (load_s) begin
            ifm_r  <= ifm;
            wght_r <= wght;
        end else begin
            ifm_r  <= ifm_r;
            wght_r <= wght_r;
        end
    end

    rng_bitrev #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rng_i (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .inc   (step_s),
        .cnt   (cnt_i_s),
        .rev   (rev_i_s)
    );

    // The weight RNG only advances on ifm ones, which decorrelates the two streams.
    rng_bitrev #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rng_w (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .inc   (inc_w_s),
        .cnt   (cnt_w_unused_s),
        .rev   (rev_w_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= UMUL_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        if (clr) begin
            state_s = UMUL_IDLE;
        end else if (en) begin
            case (state_r)
                UMUL_IDLE: begin
                    if (start) begin
                        state_s = UMUL_RUN;
                    end else begin
                        state_s = UMUL_IDLE;
                    end
                end
                UMUL_RUN: begin
                    if (last_s) begin
                        state_s = UMUL_DONE;
                    end else begin
                        state_s = UMUL_RUN;
                    end
                end
                UMUL_DONE: begin
                    if (start) begin
                        state_s = UMUL_RUN;
                    end else begin
                        state_s = UMUL_IDLE;
                    end
                end
                default: begin
                    state_s = UMUL_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output decode from registered state and counters only.
    always_comb begin
        busy     = (state_r != UMUL_IDLE);
        mac_done = (state_r == UMUL_DONE);
        prod_bit = run_s & ifm_bit_s & wght_bit_s;
    end

endmodule

// File: tb/tb_umul_rate.sv
// Directed bench for umul_rate: table of operand pairs plus hand-written multi-cycle corner cases.
module tb_umul_rate;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       start;
    logic [7:0] ifm;
    logic [7:0] wght;
`ifdef UMUL_EARLY_TERM_EN
    logic [7:0] cyc_len;
`endif
    logic       busy;
    logic       prod_bit;
    logic       mac_done;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         exp_count;
    } vec_t;

    vec_t vecs [8];

    umul_rate #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .start    (start),
        .ifm      (ifm),
        .wght     (wght),
`ifdef UMUL_EARLY_TERM_EN
        .cyc_len  (cyc_len),
`endif
        .busy     (busy),
        .prod_bit (prod_bit),
        .mac_done (mac_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present operands with start for one edge; returns at the first RUN-cycle negedge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        ifm   = a;
        wght  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count ones from the current negedge until mac_done; cycle 1 is the first RUN cycle.
    task automatic count_window(output int cnt, output int dcyc);
        cnt  = 0;
        dcyc = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (prod_bit) cnt++;
            if (mac_done) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    int cnt;
    int dcyc;
    int frozen_bad;
    int done_seen;
    logic prev_en;
    logic [2:0] snap;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; start = 1'b0; ifm = 8'd0; wght = 8'd0;
`ifdef UMUL_EARLY_TERM_EN
        cyc_len = 8'd0;
`endif
        vecs[0] = '{8'd128, 8'd128, 64};
        vecs[1] = '{8'd255, 8'd255, 255};
        vecs[2] = '{8'd64,  8'd255, 64};
        vecs[3] = '{8'd0,   8'd200, 0};
        vecs[4] = '{8'd200, 8'd0,   0};
        vecs[5] = '{8'd255, 8'd128, 128};
        vecs[6] = '{8'd128, 8'd255, 128};
        vecs[7] = '{8'd1,   8'd1,   1};

        #12;
        check("reset_busy", int'(busy), 0);
        check("reset_prod", int'(prod_bit), 0);
        check("reset_done", int'(mac_done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            launch(vecs[v].a, vecs[v].b);
            check($sformatf("busy_run_%0d", v), int'(busy), 1);
            count_window(cnt, dcyc);
            check($sformatf("count_%0dx%0d", vecs[v].a, vecs[v].b), cnt, vecs[v].exp_count);
            check($sformatf("done_cycle_%0d", v), dcyc, 257);
            @(negedge clk);
            check($sformatf("done_once_%0d", v), int'(mac_done), 0);
            check($sformatf("idle_after_%0d", v), int'(busy), 0);
        end

        // Back-to-back windows: start held in DONE re-enters RUN with no IDLE cycle.
        launch(8'd128, 8'd128);
        count_window(cnt, dcyc);
        check("b2b_first_count", cnt, 64);
        start = 1'b1; ifm = 8'd128; wght = 8'd128;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_bubble", int'(busy), 1);
        check("b2b_done_low", int'(mac_done), 0);
        count_window(cnt, dcyc);
        check("b2b_second_count", cnt, 64);
        check("b2b_second_done_cycle", dcyc, 257);
        @(negedge clk);

        // Random stalls during RUN: outputs hold while en=0, window result unchanged.
        launch(8'd128, 8'd128);
        cnt = 0; frozen_bad = 0; done_seen = 0; prev_en = 1'b1; snap = 3'b000;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (prev_en) begin
                if (prod_bit) cnt++;
                if (mac_done) begin
                    done_seen = 1;
                    break;
                end
            end else if ({busy, prod_bit, mac_done} != snap) begin
                frozen_bad++;
            end
            snap    = {busy, prod_bit, mac_done};
            en      = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            prev_en = en;
            @(negedge clk);
        end
        en = 1'b1;
        check("stall_frozen_violations", frozen_bad, 0);
        check("stall_done_seen", done_seen, 1);
        check("stall_count", cnt, 64);
        @(negedge clk);

        // clr together with start in IDLE: never leaves IDLE.
        @(negedge clk);
        start = 1'b1; clr = 1'b1; ifm = 8'd128; wght = 8'd128;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        check("clr_start_idle", int'(busy), 0);
        @(negedge clk);
        check("clr_start_still_idle", int'(busy), 0);

        // clr at RUN cycle 100 (with en low): IDLE next edge, no mac_done afterwards.
        launch(8'd128, 8'd128);
        for (int cyc = 1; cyc < 100; cyc++) @(negedge clk);
        check("clr_run_busy_before", int'(busy), 1);
        clr = 1'b1; en = 1'b0;
        @(negedge clk);
        clr = 1'b0; en = 1'b1;
        check("clr_run_idle", int'(busy), 0);
        done_seen = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (mac_done) done_seen++;
            @(negedge clk);
        end
        check("clr_run_no_done", done_seen, 0);

        // Async reset mid-RUN clears outputs immediately.
        launch(8'd255, 8'd255);
        for (int cyc = 1; cyc < 50; cyc++) @(negedge clk);
        check("rst_busy_before", int'(busy), 1);
        check("rst_prod_before", int'(prod_bit), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy_now", int'(busy), 0);
        check("rst_prod_now", int'(prod_bit), 0);
        check("rst_done_now", int'(mac_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(8'd128, 8'd128);
        count_window(cnt, dcyc);
        check("post_rst_count", cnt, 64);
        @(negedge clk);

`ifdef UMUL_EARLY_TERM_EN
        cyc_len = 8'd16;
        launch(8'd128, 8'd128);
        cyc_len = 8'd0;
        count_window(cnt, dcyc);
        check("early_count", cnt, 4);
        check("early_done_cycle", dcyc, 17);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
